// File: rtl/ascon_tag_verifier_if.sv
// Decrypt-side port bundle between the ASCON core, the tag verifier and
// the downstream plaintext consumer.
interface ascon_tag_verifier_if;
    logic         start;
    logic [63:0]  pt_block;
    logic [3:0]   pt_len;
    logic         pt_v;
    logic [127:0] core_tag;
    logic         core_tv;
    logic [127:0] rx_tag;
    logic         rx_tag_v;
    logic [63:0]  out_block;
    logic [3:0]   out_len;
    logic         out_v;
    logic         out_ready;
    logic         auth_ok;
    logic         auth_fail;
    logic         overflow;
    logic         busy;
    logic         done;

    modport master (
        output start, pt_block, pt_len, pt_v,
        output core_tag, core_tv, rx_tag, rx_tag_v, out_ready,
        input  out_block, out_len, out_v,
        input  auth_ok, auth_fail, overflow, busy, done
    );

    modport slave (
        input  start, pt_block, pt_len, pt_v,
        input  core_tag, core_tv, rx_tag, rx_tag_v, out_ready,
        output out_block, out_len, out_v,
        output auth_ok, auth_fail, overflow, busy, done
    );
endinterface

// File: rtl/ascon_tag_verifier.sv
// Buffers decrypted plaintext and releases it only after a constant-time
// 128-bit tag compare succeeds; otherwise the buffer is discarded.
module ascon_tag_verifier #(
    parameter int DEPTH = 8
) (
    input logic clk,
    input logic RST,
    ascon_tag_verifier_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, COLLECT, COMPARE, RELEASE} state_t;

    state_t        state;
    state_t        state_n;
    logic [67:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [127:0]  core_tag_q;
    logic [127:0]  rx_tag_q;
    logic          core_l;
    logic          rx_l;
    logic          auth_ok_q;
    logic          auth_fail_q;
    logic          overflow_q;
    logic          done_q;
    logic          collect;
    logic          push;
    logic          drop;
    logic          pop;
    logic          out_v;
    logic          empty;
    logic          tags_ready;
    logic          diff;
    logic          pass;

    assign empty      = (count == '0);
    assign collect    = (state == COLLECT) && !bus.start;
    assign push       = collect && bus.pt_v && (count != FULL);
    assign drop       = collect && bus.pt_v && (count == FULL);
    assign tags_ready = (core_l || bus.core_tv) && (rx_l || bus.rx_tag_v);
    // Full-width XOR reduce: timing never depends on where tags differ
    assign diff       = |(core_tag_q ^ rx_tag_q);
    assign pass       = !diff && !overflow_q;
    assign out_v      = (state == RELEASE) && !empty;
    assign pop        = out_v && bus.out_ready && !bus.start;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (bus.start) begin
            state_n = COLLECT;
        end else begin
            unique case (state)
                IDLE:    state_n = IDLE;
                COLLECT: if (tags_ready) state_n = COMPARE;
                COMPARE: state_n = pass ? RELEASE : IDLE;
                RELEASE: if (empty) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            core_tag_q  <= '0;
            rx_tag_q    <= '0;
            core_l      <= 1'b0;
            rx_l        <= 1'b0;
            auth_ok_q   <= 1'b0;
            auth_fail_q <= 1'b0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.start) begin
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                count       <= '0;
                core_l      <= 1'b0;
                rx_l        <= 1'b0;
                auth_ok_q   <= 1'b0;
                auth_fail_q <= 1'b0;
                overflow_q  <= 1'b0;
            end else begin
                unique case (state)
                    COLLECT: begin
                        if (push) begin
                            wr_ptr <= wr_ptr + 1'b1;
                            count  <= count + 1'b1;
                        end
                        if (drop) overflow_q <= 1'b1;
                        if (bus.core_tv) begin
                            core_tag_q <= bus.core_tag;
                            core_l     <= 1'b1;
                        end
                        if (bus.rx_tag_v) begin
                            rx_tag_q <= bus.rx_tag;
                            rx_l     <= 1'b1;
                        end
                    end
                    COMPARE: begin
                        core_l <= 1'b0;
                        rx_l   <= 1'b0;
                        if (pass) begin
                            auth_ok_q <= 1'b1;
                        end else begin
                            auth_fail_q <= 1'b1;
                            wr_ptr      <= '0;
                            rd_ptr      <= '0;
                            count       <= '0;
                            done_q      <= 1'b1;
                        end
                    end
                    RELEASE: begin
                        if (empty) begin
                            done_q <= 1'b1;
                        end else if (pop) begin
                            rd_ptr <= rd_ptr + 1'b1;
                            count  <= count - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Plain RAM: contents are meaningless until written after start
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.pt_block, bus.pt_len};
    end

    assign bus.out_v     = out_v;
    assign bus.out_block = out_v ? mem[rd_ptr][67:4] : '0;
    assign bus.out_len   = out_v ? mem[rd_ptr][3:0] : '0;
    assign bus.auth_ok   = auth_ok_q;
    assign bus.auth_fail = auth_fail_q;
    assign bus.overflow  = overflow_q;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
endmodule

// File: tb/tb_ascon_tag_verifier.sv
// Bench for ascon_tag_verifier: directed vector table, randomized messages
// against a message-level model, and hand-written abort/reset sequences.
module tb_ascon_tag_verifier;
    localparam int DEPTH  = 8;
    localparam int BUDGET = 200;
    localparam logic [127:0] TAG = {16{8'hA5}};

    logic clk = 1'b0;
    logic RST;

    ascon_tag_verifier_if bus();

    ascon_tag_verifier #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .RST(RST),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           pv;
        bit           ctv;
        bit           rtv;
        logic [63:0]  blk;
        logic [3:0]   len;
        logic [127:0] ct;
        logic [127:0] rt;
    } cyc_t;

    typedef struct {
        int nblk;
        int tagmode;
        bit flip;
        int rdymode;
        bit e_ok;
        bit e_fail;
        bit e_ovf;
        int e_nout;
    } vec_t;

    cyc_t        stim[$];
    bit          rdy[$];
    logic [67:0] m_exp[$];
    logic [67:0] got[$];
    int          m_t;
    int          m_done;
    bit          m_ok;
    bit          m_ovf;
    int          total = 0;
    int          bad = 0;
    vec_t        vecs[7];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic cyc_t blank();
        cyc_t e;
        e.pv = 0; e.ctv = 0; e.rtv = 0;
        e.blk = '0; e.len = '0; e.ct = '0; e.rt = '0;
        return e;
    endfunction

    function automatic bit rdy_at(int c);
        return (c < rdy.size()) ? rdy[c] : 1'b1;
    endfunction

    // Message-level model: blocks up to the cycle that completes the tag
    // pair are accepted, the first DEPTH kept, last tag strobe wins.
    task automatic model_msg();
        bit sc = 0;
        bit sr = 0;
        logic [127:0] ct = '0;
        logic [127:0] rt = '0;
        logic [67:0] blocks[$];
        int k;
        int p;
        m_exp.delete();
        m_t = -1;
        for (int c = 0; c < stim.size(); c++) begin
            if (stim[c].pv) blocks.push_back({stim[c].blk, stim[c].len});
            if (stim[c].ctv) begin ct = stim[c].ct; sc = 1; end
            if (stim[c].rtv) begin rt = stim[c].rt; sr = 1; end
            if (sc && sr) begin m_t = c; break; end
        end
        m_ovf = blocks.size() > DEPTH;
        m_ok  = !m_ovf && (ct == rt);
        if (m_ok) m_exp = blocks;
        if (!m_ok) begin
            m_done = m_t + 2;
        end else begin
            k = 0;
            p = m_t + 1;
            for (int c = m_t + 2; k < m_exp.size(); c++) begin
                if (rdy_at(c)) begin k++; p = c; end
            end
            m_done = p + 2;
        end
    endtask

    task automatic idle_inputs();
        bus.start = 0; bus.pt_v = 0; bus.core_tv = 0; bus.rx_tag_v = 0;
        bus.pt_block = '0; bus.pt_len = '0;
        bus.core_tag = '0; bus.rx_tag = '0; bus.out_ready = 0;
    endtask

    task automatic run_msg(input bit do_start);
        int inv = 0;
        int dones = 0;
        int done_c = -1;
        int first_auth = -1;
        bit stall = 0;
        bit r;
        logic [67:0] held = '0;
        model_msg();
        got.delete();
        if (do_start) begin
            @(negedge clk);
            bus.start = 1;
        end
        for (int c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                if (done_c < 0) done_c = c;
            end
            if ((bus.auth_ok || bus.auth_fail) && first_auth < 0) first_auth = c;
            if (bus.auth_ok && bus.auth_fail) inv++;
            if (!bus.out_v && (bus.out_block != '0 || bus.out_len != '0)) inv++;
            if (bus.out_v && !bus.auth_ok) inv++;
            if (stall && (!bus.out_v || {bus.out_block, bus.out_len} != held)) inv++;
            r = rdy_at(c);
            if (bus.out_v && r) got.push_back({bus.out_block, bus.out_len});
            stall = bus.out_v && !r;
            held  = {bus.out_block, bus.out_len};
            bus.start = 0;
            if (c < stim.size()) begin
                bus.pt_v = stim[c].pv; bus.pt_block = stim[c].blk;
                bus.pt_len = stim[c].len;
                bus.core_tv = stim[c].ctv; bus.core_tag = stim[c].ct;
                bus.rx_tag_v = stim[c].rtv; bus.rx_tag = stim[c].rt;
            end else begin
                bus.pt_v = 0; bus.core_tv = 0; bus.rx_tag_v = 0;
            end
            bus.out_ready = r;
            if (done_c >= 0 && c >= done_c + 2) break;
        end
        chk("done_count", dones, 1);
        chk("done_cycle", done_c, m_done);
        chk("auth_cycle", first_auth, m_t + 2);
        chk("auth_ok", bus.auth_ok, m_ok);
        chk("auth_fail", bus.auth_fail, !m_ok);
        chk("overflow", bus.overflow, m_ovf);
        chk("busy_end", bus.busy, 0);
        chk("invariants", inv, 0);
        chk("n_out", got.size(), m_exp.size());
        for (int i = 0; i < got.size() && i < m_exp.size(); i++)
            chk("block", got[i], m_exp[i]);
    endtask

    task automatic build(input vec_t v);
        cyc_t e;
        int t;
        logic [127:0] rt;
        stim.delete();
        rdy.delete();
        rt = TAG ^ {127'b0, v.flip};
        if (v.tagmode == 0) begin
            for (int i = 0; i < v.nblk; i++) begin
                e = blank();
                e.pv = 1; e.blk = {16{4'(i + 1)}}; e.len = (i % 3 == 2) ? 4'd5 : 4'd8;
                stim.push_back(e);
            end
            e = blank();
            e.ctv = 1; e.ct = TAG; e.rtv = 1; e.rt = rt;
            stim.push_back(e);
        end else begin
            e = blank();
            e.rtv = 1; e.rt = rt;
            if (v.nblk == 0) begin e.ctv = 1; e.ct = TAG; end
            stim.push_back(e);
            for (int i = 0; i < v.nblk; i++) begin
                e = blank();
                e.pv = 1; e.blk = {16{4'(i + 1)}}; e.len = (i % 3 == 2) ? 4'd5 : 4'd8;
                if (i == v.nblk - 1) begin e.ctv = 1; e.ct = TAG; end
                stim.push_back(e);
            end
        end
        t = stim.size() - 1;
        if (v.rdymode == 1) begin
            for (int c = 0; c < t + 2; c++) rdy.push_back(1'b1);
            rdy.push_back(1'b1); rdy.push_back(1'b0);
            rdy.push_back(1'b0); rdy.push_back(1'b1);
        end
    endtask

    initial begin
        cyc_t e;
        int n;
        int sent;
        bit sc;
        bit sr;
        logic [127:0] ct;
        logic [127:0] badt;

        vecs[0] = '{3, 0, 0, 0, 1, 0, 0, 3};
        vecs[1] = '{3, 0, 1, 0, 0, 1, 0, 0};
        vecs[2] = '{9, 0, 0, 0, 0, 1, 1, 0};
        vecs[3] = '{3, 1, 0, 1, 1, 0, 0, 3};
        vecs[4] = '{0, 0, 0, 0, 1, 0, 0, 0};
        vecs[5] = '{8, 1, 0, 0, 1, 0, 0, 8};
        vecs[6] = '{1, 1, 1, 1, 0, 1, 0, 0};

        idle_inputs();
        RST = 1;
        #12;
        chk("rst_out_v", bus.out_v, 0);
        chk("rst_out_block", bus.out_block, 0);
        chk("rst_flags", {bus.auth_ok, bus.auth_fail, bus.overflow}, 0);
        chk("rst_busy_done", {bus.busy, bus.done}, 0);
        @(negedge clk);
        RST = 0;

        foreach (vecs[i]) begin
            build(vecs[i]);
            run_msg(1);
            chk("tv_ok", bus.auth_ok, vecs[i].e_ok);
            chk("tv_fail", bus.auth_fail, vecs[i].e_fail);
            chk("tv_ovf", bus.overflow, vecs[i].e_ovf);
            chk("tv_nout", got.size(), vecs[i].e_nout);
        end

        for (int it = 0; it < 25; it++) begin
            stim.delete();
            rdy.delete();
            n = $urandom_range(0, 10);
            ct = {$urandom, $urandom, $urandom, $urandom};
            badt = ct ^ (128'b1 << $urandom_range(0, 127));
            sent = 0; sc = 0; sr = 0;
            while (!(sc && sr)) begin
                e = blank();
                if (sent < n && $urandom % 4 != 0) begin
                    e.pv = 1; e.blk = {$urandom, $urandom};
                    e.len = 4'($urandom_range(0, 8));
                    sent++;
                end
                if (sent == n || $urandom % 6 == 0) begin
                    e.ctv = 1; e.ct = ct; sc = 1;
                end
                if (sent == n || $urandom % 6 == 0) begin
                    e.rtv = 1; e.rt = ($urandom % 3 == 0) ? badt : ct; sr = 1;
                end
                stim.push_back(e);
            end
            for (int c = 0; c < 80; c++) rdy.push_back($urandom_range(0, 2) != 0);
            run_msg(1);
        end

        // Abort mid-release after one pop; leftover blocks must be lost
        @(negedge clk);
        bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        bus.pt_v = 1; bus.pt_block = {16{4'h1}}; bus.pt_len = 8;
        bus.rx_tag_v = 1; bus.rx_tag = TAG;
        @(negedge clk);
        bus.rx_tag_v = 0; bus.pt_block = {16{4'h2}};
        @(negedge clk);
        bus.pt_block = {16{4'h3}}; bus.pt_len = 5;
        bus.core_tv = 1; bus.core_tag = TAG;
        @(negedge clk);
        bus.pt_v = 0; bus.core_tv = 0; bus.out_ready = 1;
        @(negedge clk);
        chk("abort_first", {bus.out_v, bus.out_block}, {1'b1, {16{4'h1}}});
        @(negedge clk);
        chk("abort_second", {bus.out_v, bus.out_block}, {1'b1, {16{4'h2}}});
        bus.start = 1; bus.out_ready = 0;
        @(negedge clk);
        bus.start = 0;
        chk("abort_out_v", bus.out_v, 0);
        chk("abort_flags", {bus.auth_ok, bus.auth_fail, bus.overflow}, 0);
        chk("abort_busy", bus.busy, 1);
        stim.delete();
        rdy.delete();
        e = blank();
        e.pv = 1; e.blk = {16{4'h9}}; e.len = 3;
        e.ctv = 1; e.ct = TAG; e.rtv = 1; e.rt = TAG;
        stim.push_back(e);
        run_msg(0);

        // Async reset clears sticky auth_ok between clock edges
        build(vecs[0]);
        run_msg(1);
        @(negedge clk);
        chk("pre_rst_ok", bus.auth_ok, 1);
        #2 RST = 1;
        #1 chk("async_rst_ok", bus.auth_ok, 0);
        @(negedge clk);
        RST = 0;

        // Async reset mid-collect
        @(negedge clk);
        bus.start = 1;
        @(negedge clk);
        bus.start = 0; bus.rx_tag_v = 1; bus.rx_tag = TAG;
        @(negedge clk);
        bus.rx_tag_v = 0; bus.pt_v = 1; bus.pt_block = {16{4'h7}}; bus.pt_len = 8;
        @(negedge clk);
        bus.pt_v = 0;
        chk("collect_busy", bus.busy, 1);
        #2 RST = 1;
        #1 chk("async_rst_busy", bus.busy, 0);
        chk("async_rst_outs", {bus.out_v, bus.done, bus.overflow, bus.auth_fail}, 0);
        @(negedge clk);
        RST = 0;
        build(vecs[3]);
        run_msg(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
